// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out on x.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module fsm_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             first_bit;
  logic             next_bit;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  // x already carries bit 0 on the accept edge, so cnt tracks the bit currently on x
  assign last_bit  = (state == SHIFT) && (cnt == LAST);
`ifdef SER_PARITY_EN
  assign din_ready = !rst && ((state == IDLE) || (state == PARITY));
`else
  assign din_ready = !rst && ((state == IDLE) || last_bit);
`endif
  assign accept    = din_valid && din_ready;
  assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign next_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      x       <= IDLE_LEVEL;
      x_valid <= 1'b0;
      busy    <= 1'b0;
`ifdef SER_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (accept) begin
      state   <= SHIFT;
      sreg    <= shift_out(din);
      cnt     <= '0;
      x       <= first_bit;
      x_valid <= 1'b1;
      busy    <= 1'b1;
`ifdef SER_PARITY_EN
      par     <= ^din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (!last_bit) begin
            x    <= next_bit;
            sreg <= shift_out(sreg);
          end else begin
`ifdef SER_PARITY_EN
            state <= PARITY;
            x     <= par;
`else
            state   <= IDLE;
            x       <= IDLE_LEVEL;
            x_valid <= 1'b0;
            busy    <= 1'b0;
`endif
          end
        end
`ifdef SER_PARITY_EN
        PARITY: begin
          state   <= IDLE;
          x       <= IDLE_LEVEL;
          x_valid <= 1'b0;
          busy    <= 1'b0;
        end
`endif
        default: begin
          x       <= IDLE_LEVEL;
          x_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Directed bench for fsm_bit_serializer: an MSB-first and an LSB-first instance share one stimulus table.
// Parity expectations follow SER_PARITY_EN when it is defined for the build.
module tb_fsm_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, x, x_valid, busy;
  logic       l_ready, l_x, l_x_valid, l_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] din;
    logic       ready;
    logic       x;
    logic       xv;
    logic       busy;
    logic       lx;
  } vec_t;

  vec_t vecs[$];

  fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid), .busy(busy)
  );

  fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) lsb_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(l_ready), .x(l_x), .x_valid(l_x_valid), .busy(l_busy)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic dv, input logic [7:0] d);
    rst       = r;
    din_valid = dv;
    din       = d;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic pushRow(input logic r, input logic dv, input logic [7:0] d,
                         input logic rdy, input logic xx, input logic xv,
                         input logic b, input logic lx);
    vec_t v;
    v.rst = r; v.dv = dv; v.din = d; v.ready = rdy;
    v.x = xx; v.xv = xv; v.busy = b; v.lx = lx;
    vecs.push_back(v);
  endtask

  // One word: accept row, 7 more payload rows (optional parity row), then an idle row unless chained.
  // stall_dv keeps din_valid high with junk data while the word is in flight.
  task automatic pushWord(input logic [7:0] w, input logic stall_dv, input logic chain);
    pushRow(1'b0, 1'b1, w, 1'b1, w[7], 1'b1, 1'b1, w[0]);
    for (int k = 1; k < 8; k++)
      pushRow(1'b0, stall_dv, 8'hFF, 1'b0, w[7-k], 1'b1, 1'b1, w[k]);
    if (PAR == 1)
      pushRow(1'b0, stall_dv, 8'hFF, 1'b0, ^w, 1'b1, 1'b1, ^w);
    if (!chain)
      pushRow(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // din_ready is checked before the edge (it decides the accept); registered outputs just after it.
  task automatic runRow(input vec_t v, input int idx);
    applyStimulus(v.rst, v.dv, v.din);
    #1;
    checkOutput("din_ready", idx, din_ready, v.ready);
    checkOutput("lsb_din_ready", idx, l_ready, v.ready);
    @(posedge clk);
    #1;
    checkOutput("x", idx, x, v.x);
    checkOutput("x_valid", idx, x_valid, v.xv);
    checkOutput("busy", idx, busy, v.busy);
    checkOutput("lsb_x", idx, l_x, v.lx);
    checkOutput("lsb_x_valid", idx, l_x_valid, v.xv);
    checkOutput("lsb_busy", idx, l_busy, v.busy);
  endtask

  initial begin
    vec_t v;
    int   n;

    for (int i = 0; i < 3; i++)
      pushRow(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pushWord(8'hA5, 1'b0, 1'b0);
    pushWord(8'hA5, 1'b1, 1'b1);
    pushWord(8'h5A, 1'b0, 1'b0);
    pushWord(8'h01, 1'b1, 1'b0);
    pushWord(8'hC4, 1'b0, 1'b1);
    pushWord(8'h07, 1'b0, 1'b0);
    pushRow(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pushRow(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushWord(8'h03, 1'b0, 1'b0);

    $display("[TB] running %0d table rows", vecs.size());
    for (int i = 0; i < vecs.size(); i++)
      runRow(vecs[i], i);
    n = vecs.size();

    // Reset lands while bit 3 of 8'hFF would be clocked out; the word must vanish.
    pushRow(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    v = vecs[vecs.size()-1]; runRow(v, n++);
    for (int k = 1; k < 3; k++) begin
      pushRow(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      v = vecs[vecs.size()-1]; runRow(v, n++);
    end
    pushRow(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v = vecs[vecs.size()-1]; runRow(v, n++);

    // 8'h81 straight after reset is emitted cleanly from its bit 0.
    pushRow(1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    v = vecs[vecs.size()-1]; runRow(v, n++);
    for (int k = 1; k < 8; k++) begin
      pushRow(1'b0, 1'b0, 8'h00, 1'b0, (k == 7), 1'b1, 1'b1, (k == 7));
      v = vecs[vecs.size()-1]; runRow(v, n++);
    end
    if (PAR == 1) begin
      pushRow(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      v = vecs[vecs.size()-1]; runRow(v, n++);
    end
    pushRow(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    v = vecs[vecs.size()-1]; runRow(v, n++);
    pushRow(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    v = vecs[vecs.size()-1]; runRow(v, n++);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
